// File: rtl/cla_arb_ctrl_if.sv
// Handshake and adder bus between requesters, the round-robin controller and the
// shared registered carry-lookahead adder.
interface cla_arb_ctrl_if;
  logic        req0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        ci0;
  logic        req1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        ci1;
  logic        ack0;
  logic        ack1;
  logic [31:0] s_out;
  logic        co_out;
  logic        busy;
  logic        gnt_id;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_s;
  logic        add_co;
  logic [15:0] op_cnt;

  // Controller view
  modport slave (
    input  req0, a0, b0, ci0, req1, a1, b1, ci1, add_s, add_co,
    output ack0, ack1, s_out, co_out, busy, gnt_id, add_a, add_b, add_ci, op_cnt
  );

  // Requester/adder environment view
  modport master (
    output req0, a0, b0, ci0, req1, a1, b1, ci1, add_s, add_co,
    input  ack0, ack1, s_out, co_out, busy, gnt_id, add_a, add_b, add_ci, op_cnt
  );
endinterface

// File: rtl/cla_arb_ctrl.sv
// Two-requester round-robin controller sharing one registered CLA adder; issues
// operands, waits out the adder latency, then returns sum/carry with a 1-cycle ack.
module cla_arb_ctrl #(
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 4
) (
  input logic             clock,
  input logic             reset_n,
  cla_arb_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [CW-1:0] LAT_CNT = CW'(LAT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_grant;
  logic          r_gnt_id;
  logic          r_busy;
  logic          r_ack0;
  logic          r_ack1;
  logic [31:0]   r_s_out;
  logic          r_co_out;
  logic [31:0]   r_add_a;
  logic [31:0]   r_add_b;
  logic          r_add_ci;
  logic [15:0]   r_op_cnt;
  logic          w_win;

  // On a tie the winner is whichever requester was not granted last.
  assign w_win = bus.req1 & (~bus.req0 | ~r_last_grant);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_busy       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_s_out      <= '0;
      r_co_out     <= 1'b0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_ci     <= 1'b0;
      r_op_cnt     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_add_a      <= w_win ? bus.a1  : bus.a0;
            r_add_b      <= w_win ? bus.b1  : bus.b0;
            r_add_ci     <= w_win ? bus.ci1 : bus.ci0;
            r_gnt_id     <= w_win;
            r_last_grant <= w_win;
            r_cnt        <= LAT_CNT;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_s_out  <= bus.add_s;
            r_co_out <= bus.add_co;
            r_ack0   <= ~r_gnt_id;
            r_ack1   <= r_gnt_id;
            r_op_cnt <= r_op_cnt + 16'd1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0   = r_ack0;
  assign bus.ack1   = r_ack1;
  assign bus.s_out  = r_s_out;
  assign bus.co_out = r_co_out;
  assign bus.busy   = r_busy;
  assign bus.gnt_id = r_gnt_id;
  assign bus.add_a  = r_add_a;
  assign bus.add_b  = r_add_b;
  assign bus.add_ci = r_add_ci;
  assign bus.op_cnt = r_op_cnt;

endmodule

// File: tb/tb_cla_arb_ctrl.sv
// Bench for cla_arb_ctrl: directed vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level arbitration model.
module tb_cla_arb_ctrl;

  localparam int LAT = 2;

  logic clock;
  logic reset_n;
  cla_arb_ctrl_if bus ();

  cla_arb_ctrl #(.LAT(LAT), .CW(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered adder with LAT pipeline stages standing in for the cla_clk block.
  logic [32:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_ci);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {bus.add_co, bus.add_s} = pipe[LAT-1];

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        c0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        c1;
    logic        first_id;
    logic [32:0] sum_first;
    logic [32:0] sum_second;
  } vec_t;

  vec_t vecs [5];

  int n_pass  = 0;
  int n_total = 0;

  // Transaction-level model state
  logic        m_last;
  logic [15:0] m_ops;

  // Observed acks of the most recent transaction group
  int          got_n;
  logic        got_id  [2];
  logic        got_gnt [2];
  logic [31:0] got_s   [2];
  logic        got_co  [2];
  logic [15:0] got_oc  [2];
  int          got_t   [2];
  bit          busy_ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci);
    return {1'b0, a} + {1'b0, b} + 33'(ci);
  endfunction

  // Drive a request pattern from an idle point and record every ack until all
  // raised requests are served; each requester drops req in its ack cycle.
  task automatic collect(input logic r0, input logic r1,
                         input logic [31:0] a0v, input logic [31:0] b0v, input logic c0v,
                         input logic [31:0] a1v, input logic [31:0] b1v, input logic c1v,
                         input bit change_a0);
    int need;
    bus.req0 = r0; bus.a0 = a0v; bus.b0 = b0v; bus.ci0 = c0v;
    bus.req1 = r1; bus.a1 = a1v; bus.b1 = b1v; bus.ci1 = c1v;
    got_n   = 0;
    busy_ok = 1'b1;
    need    = int'(r0) + int'(r1);
    for (int c = 1; c <= 60 && got_n < need; c++) begin
      @(negedge clock);
      if (change_a0 && c == 1) bus.a0 = 32'h1234_5678;
      if (change_a0 && !bus.busy) busy_ok = 1'b0;
      if (bus.ack0 || bus.ack1) begin
        check("ack_exclusive", 64'(bus.ack0 & bus.ack1), 64'd0);
        got_id[got_n]  = bus.ack1;
        got_gnt[got_n] = bus.gnt_id;
        got_s[got_n]   = bus.s_out;
        got_co[got_n]  = bus.co_out;
        got_oc[got_n]  = bus.op_cnt;
        got_t[got_n]   = c;
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
        got_n++;
      end
    end
    check("ack_count", 64'(got_n), 64'(need));
    @(negedge clock);
    check("ack_width", 64'({bus.ack0, bus.ack1}), 64'd0);
    check("busy_in_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic verify_ack(input int k, input logic exp_id, input logic [32:0] exp_sum,
                            input int exp_t);
    m_ops  = m_ops + 16'd1;
    m_last = exp_id;
    if (k >= got_n) return;
    check("ack_id",  64'(got_id[k]),  64'(exp_id));
    check("gnt_id",  64'(got_gnt[k]), 64'(exp_id));
    check("s_out",   64'(got_s[k]),   64'(exp_sum[31:0]));
    check("co_out",  64'(got_co[k]),  64'(exp_sum[32]));
    check("op_cnt",  64'(got_oc[k]),  64'(m_ops));
    check("latency", 64'(got_t[k]),   64'(exp_t));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r0, r1, first;
    logic [31:0] a0v, b0v, a1v, b1v;
    logic        c0v, c1v;
    logic [31:0] ra, rb;
    logic        rc;
    int          acks, prev;

    vecs[0] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0, 32'h0, 1'b0,
                1'b0, 33'h1_0000_0000, 33'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0,
                1'b1, 33'h0_FFFF_FFFF, 33'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h135F_A562, 32'h3561_4642, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
                1'b0, 33'h0_48C0_EBA4, 33'h1_0000_0000};
    vecs[3] = vecs[2];
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1,
                1'b0, 33'h1_0000_0001, 33'h0_8000_0000};

    reset_n  = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.ci0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.ci1 = 1'b0;
    m_last = 1'b1;
    m_ops  = '0;
    repeat (2) @(negedge clock);
    check("rst_ack",    64'({bus.ack0, bus.ack1}), 64'd0);
    check("rst_s_out",  64'(bus.s_out), 64'd0);
    check("rst_co_out", 64'(bus.co_out), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_gnt_id", 64'(bus.gnt_id), 64'd0);
    check("rst_add",    64'({bus.add_a, bus.add_b, bus.add_ci}), 64'd0);
    check("rst_op_cnt", 64'(bus.op_cnt), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      collect(vecs[v].r0, vecs[v].r1, vecs[v].a0, vecs[v].b0, vecs[v].c0,
              vecs[v].a1, vecs[v].b1, vecs[v].c1, 1'b0);
      verify_ack(0, vecs[v].first_id, vecs[v].sum_first, LAT + 2);
      if (vecs[v].r0 && vecs[v].r1)
        verify_ack(1, ~vecs[v].first_id, vecs[v].sum_second, 2 * LAT + 5);
    end

    // Operand change after issue must not disturb the in-flight result
    collect(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    verify_ack(0, 1'b0, 33'h0_0000_0003, LAT + 2);
    check("busy_through_done", 64'(busy_ok), 64'd1);

    // Reset asserted while waiting on the adder abandons the operation
    bus.req0 = 1'b1; bus.a0 = 32'h0000_0010; bus.b0 = 32'h0000_0020; bus.ci0 = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_busy",   64'(bus.busy), 64'd0);
    check("midrst_ack",    64'({bus.ack0, bus.ack1}), 64'd0);
    check("midrst_s_out",  64'({bus.co_out, bus.s_out}), 64'd0);
    check("midrst_op_cnt", 64'(bus.op_cnt), 64'd0);
    check("midrst_add_a",  64'(bus.add_a), 64'd0);
    m_last = 1'b1;
    m_ops  = '0;
    @(negedge clock);
    reset_n = 1'b1;
    collect(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    verify_ack(0, 1'b0, 33'h0_0000_0031, LAT + 2);

    // Randomized transactions against the arbitration model
    for (int it = 0; it < 40; it++) begin
      r0  = 1'($urandom_range(0, 1));
      r1  = 1'($urandom_range(0, 1));
      a0v = $urandom; b0v = $urandom; c0v = 1'($urandom_range(0, 1));
      a1v = $urandom; b1v = $urandom; c1v = 1'($urandom_range(0, 1));
      if (!r0 && !r1) begin
        repeat (3) @(negedge clock);
        check("idle_hold", 64'({bus.busy, bus.ack0, bus.ack1}), 64'd0);
      end else begin
        first = (r0 && r1) ? ~m_last : r1;
        collect(r0, r1, a0v, b0v, c0v, a1v, b1v, c1v, 1'b0);
        verify_ack(0, first, first ? add33(a1v, b1v, c1v) : add33(a0v, b0v, c0v), LAT + 2);
        if (r0 && r1)
          verify_ack(1, ~first, first ? add33(a0v, b0v, c0v) : add33(a1v, b1v, c1v),
                     2 * LAT + 5);
      end
    end

    // Back-to-back operations with req0 held continuously
    ra = $urandom; rb = $urandom; rc = 1'b1;
    bus.req0 = 1'b1; bus.a0 = ra; bus.b0 = rb; bus.ci0 = rc;
    acks = 0;
    prev = 0;
    for (int c = 1; c <= 200 && acks < 20; c++) begin
      @(negedge clock);
      if (acks > 0 && c == prev + 1)
        check("b2b_ack_width", 64'(bus.ack0), 64'd0);
      if (bus.ack0) begin
        m_ops = m_ops + 16'd1;
        if (acks == 0) check("b2b_first_latency", 64'(c), 64'(LAT + 2));
        else           check("b2b_spacing", 64'(c - prev), 64'(LAT + 3));
        check("b2b_sum", 64'({bus.co_out, bus.s_out}), 64'(add33(ra, rb, rc)));
        check("b2b_op_cnt", 64'(bus.op_cnt), 64'(m_ops));
        check("b2b_ack1", 64'(bus.ack1), 64'd0);
        prev = c;
        acks++;
        if (acks == 20) bus.req0 = 1'b0;
      end
    end
    check("b2b_count", 64'(acks), 64'd20);
    repeat (3) @(negedge clock);
    check("final_idle", 64'({bus.busy, bus.ack0, bus.ack1}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
